mux_4_to_1_rr: RTL and testbench
================================

MUX_4_TO_1_RR -- requirements
Module: mux_4_to_1_rr

Interface
REQ-001 Parameter: WIDTH, default 8, data bits per channel.
REQ-002 clk  input  1  rising-edge clock; all state updates on this edge only.
REQ-003 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 in_valid  input  4  per-channel request; bit i = channel i holds a word.
REQ-005 in_data  input  4*WIDTH  channel i word at bits [i*WIDTH +: WIDTH].
REQ-006 in_ready  output  4  per-channel accept; combinational; one-hot or zero.
REQ-007 out_valid  output  1  registered; output word present.
REQ-008 out_data  output  WIDTH  registered; accepted word.
REQ-009 out_sel  output  2  registered; index of source channel (bit1 = S1, bit0 = S0), matching the 1:4 demux select encoding.
REQ-010 out_ready  input  1  downstream accept.

Function
REQ-011 Transfer rule: in a cycle, an input transfer on channel i occurs iff in_valid[i] && in_ready[i], and an output transfer occurs iff out_valid && out_ready.
REQ-012 load_en = (!out_valid || out_ready) && (in_valid != 0) && rst_n.
REQ-013 Internal 2-bit pointer ptr; grant = first i in order ptr, ptr+1, ptr+2, ptr+3 (mod 4) with in_valid[i]=1.
REQ-014 in_ready[grant] = load_en; all other in_ready bits = 0; in_ready = 4'b0000 when load_en = 0.
REQ-015 On load_en: out_data <= in_data of grant, out_sel <= grant, out_valid <= 1, ptr <= grant+1 mod 4 (3 wraps to 0).
REQ-016 Latency: accepted word appears on out_* on the clock edge after the input transfer (1 cycle).
REQ-017 Simultaneous output transfer and load: the register is replaced in the same cycle; sustained throughput is 1 word/cycle.
REQ-018 Output transfer with in_valid = 0: out_valid <= 0; out_data and out_sel hold their last values.
REQ-019 Backpressure (out_valid=1, out_ready=0): out_valid, out_data, out_sel, ptr hold unchanged; in_ready = 0.
REQ-020 ptr changes only on load_en; idle or stalled cycles do not advance ptr.
REQ-021 Fairness: with all four channels continuously valid and no stall, grants cycle 0,1,2,3,0,... with no channel granted twice before every other valid channel is granted once.
REQ-022 in_valid may drop without a transfer; the block makes no assumption of input stability (a grant is recomputed every cycle).
REQ-023 out_sel and out_data are never X after reset, including when out_valid = 0.

Reset
REQ-024 On a rising clk edge with rst_n=0: out_valid <= 0, out_data <= 0, out_sel <= 2'b00, ptr <= 2'b00.
REQ-025 While rst_n=0: in_ready = 4'b0000; no input word is accepted.
REQ-026 Reset asserted mid-operation discards any held output word without completing its transfer; first grant after release starts from channel 0.

Verification
REQ-027 Reset: rst_n=0 for 2 cycles, in_valid=4'b1111, out_ready=1 -> in_ready=0000, out_valid=0, out_sel=00, out_data=0 throughout; after release first out_sel=00.
REQ-028 Round-robin: all four valid continuously, data 0x10,0x11,0x12,0x13, out_ready=1 -> out_valid high from cycle 1 after first transfer; out_sel 0,1,2,3,0 with matching data, one per cycle.
REQ-029 Single channel: only in_valid[2], data 0x5A -> in_ready=0100 for one cycle; next cycle out_valid=1, out_sel=10, out_data=0x5A; ptr becomes 3.
REQ-030 Backpressure: out_valid=1 holding 0x11, out_ready=0 for 3 cycles with in_valid=1111 -> out_data=0x11 stable, in_ready=0000; on out_ready=1 next channel granted, no word lost or duplicated.
REQ-031 Wrap: ptr=3, in_valid=1001 -> grant ch3 then ch0 (out_sel 11 then 00).
REQ-032 Mid-operation reset: during REQ-028 stream, rst_n=0 for one cycle -> out_valid=0 next edge; after release out_sel sequence restarts at 00.

Source files
------------

// File: rtl/mux_4_to_1_rr.sv
// Four-channel round-robin arbiter feeding a single registered output slot.
// The output register is refilled whenever it is empty or being drained in the same cycle.
module mux_4_to_1_rr #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         in_valid,
  input  logic [4*WIDTH-1:0] in_data,
  output logic [3:0]         in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [1:0]         out_sel,
  input  logic               out_ready
);

  logic [1:0]       ptr_q, ptr_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;

  logic [1:0]       grant;
  logic             load_en;
  logic [WIDTH-1:0] words [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      words[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // NOTE: every combinationally driven signal gets a default before any
  // conditional assignment, so no path leaves it unassigned (no latch).
  // Scanning offsets from farthest to nearest lets the closest valid channel
  // after ptr_q overwrite the others, giving the round-robin priority.
  always_comb begin
    logic [1:0] idx;
    grant = ptr_q;
    idx   = ptr_q;
    for (int k = 3; k >= 0; k--) begin
      idx = ptr_q + 2'(k);
      if (in_valid[idx]) grant = idx;
    end
  end

  assign load_en = (!out_valid_q || out_ready) && (in_valid != 4'b0000) && rst_n;

  always_comb begin
    in_ready = 4'b0000;
    if (load_en) in_ready[grant] = 1'b1;
  end

  always_comb begin
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (load_en) begin
      ptr_d       = grant + 2'd1;
      out_valid_d = 1'b1;
      out_data_d  = words[grant];
      out_sel_d   = grant;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // update together from values sampled before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q       <= 2'b00;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'b00;
    end else begin
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_mux_4_to_1_rr.sv
// Directed bench for mux_4_to_1_rr: a vector table for reset, rotation, single
// channel and wrap, then hand-written backpressure and mid-stream reset sequences.
module tb_mux_4_to_1_rr;

  localparam int WIDTH = 8;

  logic               clk;
  logic               rst_n;
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;

  int n_checks = 0;
  int n_fails  = 0;

  mux_4_to_1_rr #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [3:0]  vld;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  rdy;
    logic        ov;
    logic [1:0]  sel;
    logic [7:0]  od;
  } vec_t;

  localparam logic [31:0] RR_DATA = 32'h13121110;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of inputs, checks in_ready before the edge and the
  // registered outputs just after it.
  task automatic step(input vec_t v);
    @(negedge clk);
    rst_n     = v.rst;
    in_valid  = v.vld;
    in_data   = v.data;
    out_ready = v.ordy;
    #1;
    check("in_ready", 32'(in_ready), 32'(v.rdy));
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(v.ov));
    check("out_sel",   32'(out_sel),   32'(v.sel));
    check("out_data",  32'(out_data),  32'(v.od));
  endtask

  vec_t vecs [15];

  initial begin
    rst_n = 1'b0; in_valid = 4'b0000; in_data = '0; out_ready = 1'b1;

    // Reset held two cycles with all channels requesting.
    vecs[0]  = '{1'b0, 4'b1111, RR_DATA, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    vecs[1]  = '{1'b0, 4'b1111, RR_DATA, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00};
    // Full rotation 0,1,2,3,0 at one word per cycle.
    vecs[2]  = '{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    vecs[3]  = '{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    vecs[4]  = '{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12};
    vecs[5]  = '{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13};
    vecs[6]  = '{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10};
    // Drain with no requests: valid drops, data/sel hold, ptr stays at 1.
    vecs[7]  = '{1'b1, 4'b0000, RR_DATA, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h10};
    // Single channel 2, then idle; ptr moves to 3.
    vecs[8]  = '{1'b1, 4'b0100, 32'h005A0000, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h5A};
    vecs[9]  = '{1'b1, 4'b0000, 32'h005A0000, 1'b1, 4'b0000, 1'b0, 2'd2, 8'h5A};
    // Wrap from ptr=3 with channels 3 and 0: grant 3 then 0.
    vecs[10] = '{1'b1, 4'b1001, 32'h33000030, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h33};
    vecs[11] = '{1'b1, 4'b1001, 32'h33000030, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h30};
    vecs[12] = '{1'b1, 4'b0000, 32'h33000030, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h30};
    // ptr now 1: load channel 1 (0x11) ahead of the backpressure sequence.
    vecs[13] = '{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11};
    // Backpressure: word 0x11 must stay put and nothing is accepted.
    vecs[14] = '{1'b1, 4'b1111, RR_DATA, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11};

    for (int i = 0; i < 15; i++) step(vecs[i]);

    // Two more stalled cycles, then release: channel 2 then 3, no loss/dup.
    repeat (2) step('{1'b1, 4'b1111, RR_DATA, 1'b0, 4'b0000, 1'b1, 2'd1, 8'h11});
    step('{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b0100, 1'b1, 2'd2, 8'h12});
    step('{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b1000, 1'b1, 2'd3, 8'h13});

    // Mid-stream reset: held word discarded, rotation restarts at channel 0.
    step('{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10});
    step('{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11});
    step('{1'b0, 4'b1111, RR_DATA, 1'b1, 4'b0000, 1'b0, 2'd0, 8'h00});
    step('{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b0001, 1'b1, 2'd0, 8'h10});
    step('{1'b1, 4'b1111, RR_DATA, 1'b1, 4'b0010, 1'b1, 2'd1, 8'h11});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
